muldiv_sequencer: RTL and testbench

Multi-cycle controller for the processor's multiply (ALU_Control 4'b0101) and divide (ALU_Control 4'b1011) operations, which the single-cycle ALU cannot finish in one clock. It accepts one operation at a time and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. Meanwhile it stalls the pipeline, then writes the 2×WIDTH result into HI/LO. It sits beside the ALU, decoding the same ALU_Control code.

---
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller: iterative shift-add multiply and restoring divide.
// Optional MULDIV_SIGNED_EN enables two's-complement operation; default build is unsigned.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [3:0]       ALU_Control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [3:0] OP_MULT = 4'b0101;
   localparam logic [3:0] OP_DIV  = 4'b1011;
   localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

   state_t                   state, state_nxt;
   logic                     start_ok;
   logic                     in_flight;
   logic                     op_div;
   logic [CNT_W-1:0]         cnt;
   logic signed [WIDTH-1:0]  a_lat;
   logic signed [WIDTH-1:0]  b_lat;
   logic [WIDTH-1:0]         mcand;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]         acc;     // product upper half or partial remainder
   logic [WIDTH-1:0]         mq;      // multiplier or dividend/quotient
   logic [WIDTH:0]           add_sum;
   logic [WIDTH:0]           rem_sh;
   logic [WIDTH-1:0]         div_trial;
   logic                     div_keep;
   logic [WIDTH-1:0]         hi_fix, lo_fix;
   logic                     divzero_fix;
`ifdef MULDIV_SIGNED_EN
   logic                     neg_res, neg_rem;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      mag = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      neg_w = ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      neg_2w = ~v + (2*WIDTH)'(1);
   endfunction
`endif

   assign start_ok  = Start && (ALU_Control == OP_MULT || ALU_Control == OP_DIV);
   assign in_flight = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_PREP;
         S_PREP:  state_nxt = S_RUN;
         S_RUN:   if (cnt == '0) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (Flush && in_flight) state_nxt = S_IDLE;
   end

   always_comb begin
      Busy  = (state != S_IDLE);
      Done  = (state == S_DONE);
      Stall = Reset_n && ((state == S_IDLE && start_ok) || in_flight);
   end

   // Control: operation select and iteration counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt    <= '0;
         op_div <= 1'b0;
      end else begin
         if (state == S_IDLE && start_ok) op_div <= (ALU_Control == OP_DIV);
         if (Flush && in_flight)                    cnt <= '0;
         else if (state == S_PREP)                  cnt <= CNT_W'(WIDTH - 1);
         else if (state == S_RUN && cnt != '0)      cnt <= cnt - CNT_W'(1);
      end
   end

   always_comb begin
      add_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
      rem_sh    = {acc, mq[WIDTH-1]};
      div_keep  = (rem_sh >= {1'b0, mcand});
      div_trial = rem_sh[WIDTH-1:0] - mcand;
   end

   // Datapath: operand latch, PREP conditioning, one iteration per RUN cycle
   always_ff @(posedge Clk) begin
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               a_lat <= A;
               b_lat <= B;
            end
         end
         S_PREP: begin
            acc <= '0;
`ifdef MULDIV_SIGNED_EN
            mcand   <= op_div ? mag(b_lat) : mag(a_lat);
            mq      <= op_div ? mag(a_lat) : mag(b_lat);
            neg_res <= a_lat[WIDTH-1] ^ b_lat[WIDTH-1];
            neg_rem <= a_lat[WIDTH-1];
`else
            mcand <= op_div ? b_lat : a_lat;
            mq    <= op_div ? a_lat : b_lat;
`endif
         end
         S_RUN: begin
            if (op_div) begin
               acc <= div_keep ? div_trial : rem_sh[WIDTH-1:0];
               mq  <= {mq[WIDTH-2:0], div_keep};
            end else begin
               {acc, mq} <= {add_sum, mq[WIDTH-1:1]};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      hi_fix      = acc;
      lo_fix      = mq;
      divzero_fix = 1'b0;
`ifdef MULDIV_SIGNED_EN
      if (op_div) begin
         if (neg_res) lo_fix = neg_w(mq);
         if (neg_rem) hi_fix = neg_w(acc);
      end else if (neg_res) begin
         {hi_fix, lo_fix} = neg_2w({acc, mq});
      end
`endif
      if (op_div && b_lat == '0) begin
         lo_fix      = '1;
         hi_fix      = a_lat;
         divzero_fix = 1'b1;
      end
   end

   // Result registers load only on the FIX -> DONE edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         HI      <= '0;
         LO      <= '0;
         DivZero <= 1'b0;
      end else if (state == S_FIX && !Flush) begin
         HI      <= hi_fix;
         LO      <= lo_fix;
         DivZero <= divzero_fix;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: hand vectors, corner sequences, random ops vs model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

   localparam int         W       = 32;
   localparam int         LAT     = W + 3;
   localparam logic [3:0] OP_MULT = 4'b0101;
   localparam logic [3:0] OP_DIV  = 4'b1011;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic         Start;
   logic [3:0]   ALU_Control;
   logic [W-1:0] A, B;
   logic         Flush;
   logic         Stall, Busy, Done, DivZero;
   logic [W-1:0] HI, LO;

   int           vectors     = 0;
   int           miscompares = 0;
   logic [64:0]  last_res;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t tbl [0:7];

   muldiv_sequencer #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ALU_Control(ALU_Control),
      .A(A), .B(B), .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done),
      .DivZero(DivZero), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on 64-bit values; returns {DivZero, HI, LO}
   function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, q, r;
      logic [31:0] qu, ru;
      sa = $signed(a);
      sb = $signed(b);
      if (op == OP_MULT) begin
`ifdef MULDIV_SIGNED_EN
         p = 64'(sa * sb);
`else
         p = {32'd0, a} * {32'd0, b};
`endif
         return {1'b0, p};
      end
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
`ifdef MULDIV_SIGNED_EN
      q = sa / sb;
      r = sa % sb;
      return {1'b0, 32'(r), 32'(q)};
`else
      qu = a / b;
      ru = a % b;
      return {1'b0, ru, qu};
`endif
   endfunction

   // mode 0: plain; 1: extra Start pulses mid-RUN; 2: Flush held in IDLE and DONE cycles
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input logic [64:0] exp, input string tag);
      int          done_cyc, done_cnt, stall_cnt;
      logic        stall_c0, stall_at_done;
      logic [64:0] got;
      done_cyc = -1; done_cnt = 0; stall_cnt = 0; stall_at_done = 1'b1; got = '0;
      Start = 1'b1; ALU_Control = op; A = a; B = b;
      Flush = (mode == 2);
      #1;
      stall_c0 = Stall;
      if (Stall) stall_cnt++;
      for (int c = 1; c <= LAT + 1; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0; ALU_Control = 4'b0000; A = $urandom; B = $urandom; Flush = 1'b0;
         if (mode == 1 && c == 10) begin Start = 1'b1; ALU_Control = OP_DIV; end
         if (mode == 1 && c == 12) begin Start = 1'b1; ALU_Control = 4'b0010; end
         if (mode == 2 && c == LAT) Flush = 1'b1;
         #1;
         if (Stall) stall_cnt++;
         if (Done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc      = c;
               stall_at_done = Stall;
               got           = {DivZero, HI, LO};
            end
         end
      end
      Flush = 1'b0;
      chk({tag, " stall_c0"}, 65'(stall_c0), 65'd1);
      chk({tag, " done_cycle"}, 65'(done_cyc), 65'(LAT));
      chk({tag, " done_pulses"}, 65'(done_cnt), 65'd1);
      chk({tag, " stall_cycles"}, 65'(stall_cnt), 65'(LAT));
      chk({tag, " stall_at_done"}, 65'(stall_at_done), 65'd0);
      chk({tag, " result"}, got, exp);
      chk({tag, " result_hold"}, {DivZero, HI, LO}, exp);
      chk({tag, " idle_after"}, 65'(Busy), 65'd0);
      last_res = exp;
   endtask

   task automatic flush_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int fcyc, input string tag);
      int   done_cnt;
      logic busy_after;
      done_cnt = 0; busy_after = 1'b1;
      Start = 1'b1; ALU_Control = op; A = a; B = b; Flush = 1'b0;
      for (int c = 1; c <= LAT + 2; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0; ALU_Control = 4'b0000;
         Flush = (c == fcyc);
         #1;
         if (Done) done_cnt++;
         if (c == fcyc + 1) busy_after = Busy;
      end
      Flush = 1'b0;
      chk({tag, " busy_after_flush"}, 65'(busy_after), 65'd0);
      chk({tag, " no_done"}, 65'(done_cnt), 65'd0);
      chk({tag, " result_kept"}, {DivZero, HI, LO}, last_res);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          x;

      tbl[0] = '{OP_MULT, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 1'b0};
`ifdef MULDIV_SIGNED_EN
      tbl[1] = '{OP_MULT, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tbl[3] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[5] = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
      tbl[6] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[7] = '{OP_MULT, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
`else
      tbl[1] = '{OP_MULT, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
      tbl[3] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
      tbl[5] = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[6] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
      tbl[7] = '{OP_MULT, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000, 1'b0};
`endif
      tbl[2] = '{OP_DIV,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      tbl[4] = '{OP_DIV,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};

      Reset_n = 1'b0; Start = 1'b1; ALU_Control = OP_MULT; A = 32'd3; B = 32'd4; Flush = 1'b0;
      last_res = '0;
      #3;
      chk("reset stall", 65'(Stall), 65'd0);
      chk("reset busy", 65'(Busy), 65'd0);
      chk("reset done", 65'(Done), 65'd0);
      chk("reset outputs", {DivZero, HI, LO}, 65'd0);
      @(posedge Clk); #1;
      Start = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      @(posedge Clk); #1;
      chk("post-reset idle", 65'(Busy), 65'd0);

      for (int i = 0; i <= 7; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, {tbl[i].dz, tbl[i].hi, tbl[i].lo}, $sformatf("tbl%0d", i));

      run_op(OP_MULT, 32'd9, 32'd8, 1, model(OP_MULT, 32'd9, 32'd8), "midrun_start");
      run_op(OP_DIV, 32'd1000, 32'd33, 2, model(OP_DIV, 32'd1000, 32'd33), "flush_idle_done");
      flush_op(OP_DIV, 32'd77, 32'd0, 10, "flush_run");
      flush_op(OP_MULT, 32'd123, 32'd456, LAT - 1, "flush_fix");
      flush_op(OP_MULT, 32'd5, 32'd5, 1, "flush_prep");

      // Invalid op code in IDLE is not accepted
      Start = 1'b1; ALU_Control = 4'b0010; #1;
      chk("bad_op stall", 65'(Stall), 65'd0);
      @(posedge Clk); #1;
      Start = 1'b0; #1;
      chk("bad_op busy", 65'(Busy), 65'd0);

      // Asynchronous reset mid-operation
      Start = 1'b1; ALU_Control = OP_MULT; A = 32'd9; B = 32'd9;
      for (int c = 1; c <= 20; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
      end
      Reset_n = 1'b0; Start = 1'b1; ALU_Control = OP_DIV;
      #1;
      chk("midreset busy", 65'(Busy), 65'd0);
      chk("midreset stall", 65'(Stall), 65'd0);
      chk("midreset done", 65'(Done), 65'd0);
      chk("midreset outputs", {DivZero, HI, LO}, 65'd0);
      @(posedge Clk); #1;
      Reset_n = 1'b1; Start = 1'b0;
      @(posedge Clk); #1;
      chk("release idle", 65'(Busy), 65'd0);
      run_op(OP_MULT, 32'd11, 32'd13, 0, model(OP_MULT, 32'd11, 32'd13), "after_reset");

      for (int i = 0; i < 30; i++) begin
         op = $urandom_range(0, 1) ? OP_DIV : OP_MULT;
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 4))
            0: b = $urandom_range(0, 15);
            1: b = 32'd0;
            2: a = $urandom_range(0, 1000);
            default: ;
         endcase
         run_op(op, a, b, 0, model(op, a, b), $sformatf("rand%0d", i));
         if (i % 6 == 0) begin
            x = $urandom_range(0, 15);
            if (x == 5 || x == 11) x = 0;
            Start = 1'b1; ALU_Control = 4'(x); #1;
            chk("rand bad_op stall", 65'(Stall), 65'd0);
            @(posedge Clk); #1;
            Start = 1'b0; #1;
            chk("rand bad_op busy", 65'(Busy), 65'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
